admin_regfile: RTL and testbench

- CPU-side responder for the register admin port: owns the 32x32 general register file.
- Accepts operator preload writes while in the admin phase and raises reg_admin_ena for that whole phase.
- Hands the file over to the CPU datapath on a go pulse, and freezes it on halt.
- Exposes registers 1..5 packed on oreg for the VGA display path.

---
 rtl/admin_regfile_pkg.sv | 12 +
 rtl/admin_regfile_core.sv | 55 +++++
 rtl/admin_regfile.sv | 99 +++++++++
 tb/tb_admin_regfile.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/admin_regfile_pkg.sv
// Shared constants for the admin register-file slice: phase encoding and widths.
package admin_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DW_DEF     = 32;

    localparam logic [1:0] ST_ADMIN = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/admin_regfile_core.sv
// Register storage: one write port, two combinational read ports, a hardwired
// zero register and a packed window of consecutive registers for display.
module regfile_core
    import admin_regfile_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DW         = DW_DEF,
    parameter int OREG_FIRST = 1,
    parameter int OREG_COUNT = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [REG_ADDR_W-1:0]    waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [REG_ADDR_W-1:0]    rs_addr,
    output logic [DW-1:0]            rs_data,
    input  logic [REG_ADDR_W-1:0]    rt_addr,
    output logic [DW-1:0]            rt_data,
    output logic [OREG_COUNT*DW-1:0] oreg
);

    logic [DW-1:0] mem_q [NUM_REGS];
    logic [DW-1:0] mem_d [NUM_REGS];

    // Index 0 and indices beyond the array never take a write, so entry 0 stays zero.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0) && (int'(waddr) < NUM_REGS)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if ((rs_addr != '0) && (int'(rs_addr) < NUM_REGS)) rs_data = mem_q[rs_addr];
        if ((rt_addr != '0) && (int'(rt_addr) < NUM_REGS)) rt_data = mem_q[rt_addr];
    end

    for (genvar g = 0; g < OREG_COUNT; g++) begin : g_oreg
        assign oreg[g*DW +: DW] = mem_q[OREG_FIRST + g];
    end

endmodule

// File: rtl/admin_regfile.sv
// CPU-side admin port responder: phase FSM (ADMIN/ARM/RUN/HALT), write-port
// steering between the operator and the CPU, and the sticky admin_err flag.
module admin_regfile
    import admin_regfile_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DW         = DW_DEF,
    parameter int OREG_FIRST = 1,
    parameter int OREG_COUNT = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     admin_we,
    input  logic [REG_ADDR_W-1:0]    admin_addr,
    input  logic [DW-1:0]            admin_data,
    input  logic                     admin_go,
    output logic                     reg_admin_ena,
    output logic                     cpu_run,
    input  logic [REG_ADDR_W-1:0]    rs_addr,
    output logic [DW-1:0]            rs_data,
    input  logic [REG_ADDR_W-1:0]    rt_addr,
    output logic [DW-1:0]            rt_data,
    input  logic                     cpu_we,
    input  logic [REG_ADDR_W-1:0]    cpu_waddr,
    input  logic [DW-1:0]            cpu_wdata,
    input  logic                     cpu_halt,
    output logic [OREG_COUNT*DW-1:0] oreg,
    output logic                     admin_err,
    output logic [1:0]               state_dbg
);

    // Handshake: the admin master may issue admin_we only while reg_admin_ena
    // is high; the one-cycle ARM gap lets it observe ena fall before the CPU
    // takes ownership (cpu_run high). No ready path: writes are never stalled.

    logic [1:0]            state_q, state_d;
    logic                  admin_err_q, admin_err_d;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DW-1:0]         wr_data;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_addr = admin_addr;
        wr_data = admin_data;
        case (state_q)
            ST_ADMIN: begin
                wr_en = admin_we;
                if (admin_go) state_d = ST_ARM;
            end
            ST_ARM: state_d = ST_RUN;
            ST_RUN: begin
                wr_en   = cpu_we;
                wr_addr = cpu_waddr;
                wr_data = cpu_wdata;
                if (cpu_halt) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    assign admin_err_d = admin_err_q | (admin_we && (state_q != ST_ADMIN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ADMIN;
            admin_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            admin_err_q <= admin_err_d;
        end
    end

    // Status outputs decode the state flops only, so go/halt never reach them combinationally.
    assign reg_admin_ena = (state_q == ST_ADMIN);
    assign cpu_run       = (state_q == ST_RUN);
    assign admin_err     = admin_err_q;
    assign state_dbg     = state_q;

    regfile_core #(
        .NUM_REGS   (NUM_REGS),
        .DW         (DW),
        .OREG_FIRST (OREG_FIRST),
        .OREG_COUNT (OREG_COUNT)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .rs_addr (rs_addr),
        .rs_data (rs_data),
        .rt_addr (rt_addr),
        .rt_data (rt_data),
        .oreg    (oreg)
    );

endmodule

// File: tb/tb_admin_regfile.sv
// Bench for admin_regfile: directed phase walk-through plus randomized traffic
// checked every cycle against a behavioural model of the register file.
module tb_admin_regfile;

    localparam int DW = 32;
    localparam int OW = 5 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          admin_we = 1'b0;
    logic [4:0]    admin_addr = '0;
    logic [DW-1:0] admin_data = '0;
    logic          admin_go = 1'b0;
    logic          reg_admin_ena;
    logic          cpu_run;
    logic [4:0]    rs_addr = '0;
    logic [DW-1:0] rs_data;
    logic [4:0]    rt_addr = '0;
    logic [DW-1:0] rt_data;
    logic          cpu_we = 1'b0;
    logic [4:0]    cpu_waddr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_halt = 1'b0;
    logic [OW-1:0] oreg;
    logic          admin_err;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    admin_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .admin_we      (admin_we),
        .admin_addr    (admin_addr),
        .admin_data    (admin_data),
        .admin_go      (admin_go),
        .reg_admin_ena (reg_admin_ena),
        .cpu_run       (cpu_run),
        .rs_addr       (rs_addr),
        .rs_data       (rs_data),
        .rt_addr       (rt_addr),
        .rt_data       (rt_data),
        .cpu_we        (cpu_we),
        .cpu_waddr     (cpu_waddr),
        .cpu_wdata     (cpu_wdata),
        .cpu_halt      (cpu_halt),
        .oreg          (oreg),
        .admin_err     (admin_err),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 admin, 1 arm, 2 run, 3 halt
    logic [DW-1:0] m_regs [32];
    int            m_phase = 0;
    bit            m_err = 1'b0;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_phase = 0;
        m_err   = 1'b0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_clear();
        end else begin
            if (admin_we && m_phase != 0) m_err = 1'b1;
            if (m_phase == 0) begin
                if (admin_we && admin_addr != 0) m_regs[admin_addr] = admin_data;
                if (admin_go) m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (cpu_we && cpu_waddr != 0) m_regs[cpu_waddr] = cpu_wdata;
                if (cpu_halt) m_phase = 3;
            end
        end
    end

    function automatic logic [OW-1:0] exp_oreg();
        logic [OW-1:0] r;
        for (int i = 0; i < 5; i++) r[i*DW +: DW] = m_regs[1 + i];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en && rst) begin
            check("ena",   OW'(reg_admin_ena), OW'(m_phase == 0));
            check("run",   OW'(cpu_run),       OW'(m_phase == 2));
            check("err",   OW'(admin_err),     OW'(m_err));
            check("state", OW'(state_dbg),     OW'(m_phase));
            check("oreg",  oreg,               exp_oreg());
            check("rs",    OW'(rs_data),       OW'(m_regs[rs_addr]));
            check("rt",    OW'(rt_data),       OW'(m_regs[rt_addr]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        admin_we = 1'b0; admin_go = 1'b0; cpu_we = 1'b0; cpu_halt = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic rand_cycle(input int we_pct, input int go_pct, input int halt_pct, input int aw_pct);
        admin_we   = ($urandom_range(0, 99) < aw_pct);
        admin_addr = 5'($urandom_range(0, 31));
        admin_data = $urandom;
        admin_go   = ($urandom_range(0, 99) < go_pct);
        cpu_we     = ($urandom_range(0, 99) < we_pct);
        cpu_waddr  = 5'($urandom_range(0, 31));
        cpu_wdata  = $urandom;
        cpu_halt   = ($urandom_range(0, 99) < halt_pct);
        rs_addr    = 5'($urandom_range(0, 31));
        rt_addr    = 5'($urandom_range(0, 31));
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        cmp_en = 1'b1;

        // Reset state
        tick();
        check("rst_ena",  OW'(reg_admin_ena), OW'(1));
        check("rst_run",  OW'(cpu_run),       OW'(0));
        check("rst_err",  OW'(admin_err),     OW'(0));
        check("rst_oreg", oreg,               '0);
        rs_addr = 5'd17; #1;
        check("rst_rs",   OW'(rs_data),       OW'(0));

        // Admin preload, including a discarded write to reg0
        admin_we = 1'b1; admin_addr = 5'd4; admin_data = 32'h1234; tick();
        check("oreg_r4", OW'(oreg[127:96]), OW'(32'h1234));
        admin_addr = 5'd5; admin_data = 32'hFFFF; tick();
        check("oreg_r5", OW'(oreg[159:128]), OW'(32'hFFFF));
        admin_addr = 5'd0; admin_data = 32'hDEAD; rs_addr = 5'd0; tick();
        check("r0_zero", OW'(rs_data), OW'(0));

        // Write and go together, then ARM, then RUN
        admin_addr = 5'd3; admin_data = 32'd7; admin_go = 1'b1; rt_addr = 5'd3; tick();
        idle_inputs();
        check("go_wr",   OW'(rt_data),       OW'(7));
        check("arm_ena", OW'(reg_admin_ena), OW'(0));
        check("arm_run", OW'(cpu_run),       OW'(0));
        tick();
        check("run_on",  OW'(cpu_run),       OW'(1));

        // CPU write with a stray admin write
        cpu_we = 1'b1; cpu_waddr = 5'd1; cpu_wdata = 32'hA5A5A5A5;
        admin_we = 1'b1; admin_addr = 5'd2; admin_data = 32'd9; tick();
        idle_inputs();
        check("cpu_r1",   OW'(oreg[31:0]),  OW'(32'hA5A5A5A5));
        check("r2_keep",  OW'(oreg[63:32]), OW'(0));
        check("err_set",  OW'(admin_err),   OW'(1));
        tick();
        check("err_hold", OW'(admin_err),   OW'(1));

        // Write and halt together, then frozen
        cpu_we = 1'b1; cpu_waddr = 5'd2; cpu_wdata = 32'd5; cpu_halt = 1'b1; tick();
        idle_inputs();
        check("halt_wr",  OW'(oreg[63:32]), OW'(5));
        check("halt_run", OW'(cpu_run),     OW'(0));
        cpu_we = 1'b1; cpu_wdata = 32'd6; tick();
        idle_inputs();
        check("halt_frz", OW'(oreg[63:32]), OW'(5));

        // Asynchronous reset in RUN with a write pending
        do_reset();
        admin_we = 1'b1; admin_addr = 5'd1; admin_data = 32'h55; admin_go = 1'b1; tick();
        idle_inputs(); tick();
        admin_we = 1'b1; tick();
        admin_we = 1'b0;
        check("pre_run", OW'(cpu_run), OW'(1));
        cpu_we = 1'b1; cpu_waddr = 5'd2; cpu_wdata = 32'h77;
        #2 rst = 1'b0;
        #1;
        check("ar_ena",  OW'(reg_admin_ena), OW'(1));
        check("ar_run",  OW'(cpu_run),       OW'(0));
        check("ar_err",  OW'(admin_err),     OW'(0));
        check("ar_oreg", oreg,               '0);
        idle_inputs();
        tick();
        rst = 1'b1;

        // Randomized phases
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int c = 0; c < int'($urandom_range(4, 20)); c++) rand_cycle(50, 5, 0, 60);
            admin_go = 1'b1; tick(); idle_inputs();
            for (int c = 0; c < 40; c++) rand_cycle(60, 20, 4, 5);
            for (int c = 0; c < 8; c++) rand_cycle(60, 20, 100, 20);
        end

        idle_inputs();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
